spi_ram_burst_slave: RTL and testbench
======================================

# spi_ram_burst_slave

Parametrised SPI slave with an embedded single-port RAM, the next generation of our fixed 8-bit SPI-to-RAM top. It decodes the same 2-bit command set (write address, write data, read address, read data), generalises address/data width, and adds burst transfers: while `ss_n` stays low, consecutive data words are written or read back-to-back with auto-incrementing addresses. It sits directly on the SPI pins; `clk` is the SPI bit clock.

## Interface
- `ADDR_WIDTH`, 8: RAM address bits; depth is fixed at 2**ADDR_WIDTH.
- `DATA_WIDTH`, 8: RAM word width and data-word length on the wire.
- `AUTO_INC`, 1: 1 = address increments after each burst word; 0 = the address holds, so repeated words hit the same location.
- `clk` in 1: bit clock; all sampling and state updates are on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ss_n` in 1: slave select, active low; high aborts and ends any frame.
- `mosi` in 1: serial input, MSB first, sampled on rising `clk`.
- `miso` out 1: serial output, MSB first, registered.

## Operation
- States are IDLE, CMD, RX_ADDR, RX_DATA, TX_DATA.
- IDLE: on the first rising edge with `ss_n`=0, go to CMD. `mosi` is ignored on that edge.
- CMD: the next 2 edges sample the command bits, MSB first.
- Command 00 -> RX_ADDR (write address), loading `wr_addr`.
- Command 10 -> RX_ADDR (read address), loading `rd_addr`.
- Command 01 -> RX_DATA.
- Command 11 -> TX_DATA.
- RX_ADDR:
  - Shift ADDR_WIDTH bits.
  - On the edge that samples the last bit, load the target pointer.
  - Any further bits are ignored until `ss_n` goes high.
- RX_DATA:
  - Shift DATA_WIDTH bits per word.
  - Each completed word writes to mem[`wr_addr`] on the following edge.
  - After each write, `wr_addr` += 1 modulo depth if AUTO_INC=1.
  - The next word starts immediately; burst length is unlimited.
- TX_DATA:
  - Read mem[`rd_addr`] and shift it out MSB first.
  - The next word is prefetched while the current one is shifting, so words are contiguous with no gap bits.
  - `rd_addr` += 1 modulo depth after each word is fetched (AUTO_INC=1).
  - `mosi` is ignored.
- `ss_n` high on any edge:
  - Return to IDLE and drive `miso` to 0.
  - Discard any partial address or data word: no write, pointer unchanged.
  - Completed words and pointer updates are kept.
- Undriven periods: `miso` = 0 whenever the state is not TX_DATA.
- Memory contents are not reset.

## Timing
- Reset values:
  - `miso` = 0, state = IDLE.
  - `wr_addr` = 0, `rd_addr` = 0.
  - Shift counters = 0.
- Reset asserted mid-frame: the write of a word whose commit edge has not yet occurred is lost.
- Command decode: with edge 0 being the first edge with `ss_n` low, command bits are sampled on edges 1 and 2.
- Write latency:
  - The word's last bit is sampled on edge N; the RAM is written on edge N+1.
  - A read of the same address in a later frame returns the new value.
- Read latency:
  - With edge 2 sampling the last command bit, the MSB of word 0 is on `miso` after edge 4.
  - Each following bit appears after each following edge.
  - Word k's MSB follows word k-1's LSB on the next edge.
- Wrap-around: address 2**ADDR_WIDTH-1 increments to 0 for both reads and writes.
- Pointer independence: `wr_addr` and `rd_addr` are independent. Writing never disturbs `rd_addr`, and vice versa.
- Single port: only one RAM access per cycle. RX_DATA and TX_DATA are mutually exclusive, so no arbitration is needed.

## Structure
- Shared package `spi_ram_pkg`:
  - Command codes: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - State enum.
- Sub-module `spi_ram_sp_mem`:
  - Parametrised single-port RAM.
  - Ports: clk, en, we, addr, din, dout.
  - Registered read, 1-cycle latency.
- Top: FSM, shift registers, bit counter, pointers, `miso` output register.

## Test plan
- Reset: `rst_n`=0 with `ss_n`=1 -> `miso`=0.
- Reset mid-stream: assert `rst_n`=0 during TX_DATA -> `miso`=0 immediately; pointers read back as 0.
- Single write/read:
  - Write address 0x12, write data 0xA5, read address 0x12, read data.
  - Required: `miso` serialises 1010_0101 starting 2 edges after the command.
- Burst write:
  - Write address 0xFE, then words 0x11, 0x22, 0x33 in one frame.
  - Required: reads return mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap).
- Burst read:
  - Read address 0xFE, read data with 3×DATA_WIDTH clocks.
  - Required: `miso` shows 0x11, 0x22, 0x33 contiguously with no gap bits.
- Abort: `ss_n` high after 5 bits of a data word -> location unchanged, `wr_addr` unchanged, `miso`=0.
- Parameter sweep:
  - ADDR_WIDTH=4, DATA_WIDTH=16, AUTO_INC=0.
  - Burst write 0xBEEF then 0xCAFE to address 0x3 -> mem[0x3]=0xCAFE, mem[0x4] untouched.

Source files
------------

// File: rtl/spi_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_ram_pkg : command codes and FSM states for spi_ram_burst_slave |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_RX_ADDR = 3'd2,
        ST_RX_DATA = 3'd3,
        ST_TX_DATA = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_ram_sp_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_ram_sp_mem : single-port RAM, registered read (1-cycle)        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_ram_sp_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_ram_burst_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_ram_burst_slave : SPI slave with embedded RAM and burst access |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_ram_burst_slave
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic mosi,
    output logic miso
);

    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] ADDR_DONE = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           sh;
    logic                    cmd_msb;
    logic                    rd_sel;
    logic                    tx_run;
    logic                    wr_pend;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    logic [SW-1:0]           sh_next;
    logic                    tx_fetch;
    logic                    mem_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_dout;

    assign sh_next  = {sh[SW-2:0], mosi};
    // Fetch on the first TX edge and on every word-load edge, so the next
    // word sits in the RAM output register while the current one shifts.
    assign tx_fetch = (state == ST_TX_DATA) && !ss_n && (cnt == '0);
    // A pending write only ever follows RX_DATA, so it never meets a fetch.
    assign mem_en   = wr_pend | tx_fetch;
    assign mem_addr = wr_pend ? wr_addr : rd_addr;

    spi_ram_sp_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk  (clk),
        .en   (mem_en),
        .we   (wr_pend),
        .addr (mem_addr),
        .din  (wr_word),
        .dout (mem_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sh      <= '0;
            cmd_msb <= 1'b0;
            rd_sel  <= 1'b0;
            tx_run  <= 1'b0;
            wr_pend <= 1'b0;
            wr_word <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            miso    <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend && (AUTO_INC != 0)) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
            if (tx_fetch && (AUTO_INC != 0)) begin
                rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end

            if (ss_n) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                tx_run <= 1'b0;
                miso   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_CMD;
                        cnt   <= '0;
                    end
                    ST_CMD: begin
                        if (cnt == '0) begin
                            cmd_msb <= mosi;
                            cnt     <= CW'(1);
                        end else begin
                            cnt <= '0;
                            case ({cmd_msb, mosi})
                                CMD_WR_ADDR: begin state <= ST_RX_ADDR; rd_sel <= 1'b0; end
                                CMD_RD_ADDR: begin state <= ST_RX_ADDR; rd_sel <= 1'b1; end
                                CMD_WR_DATA: state <= ST_RX_DATA;
                                CMD_RD_DATA: state <= ST_TX_DATA;
                                default:     state <= ST_IDLE;
                            endcase
                        end
                    end
                    ST_RX_ADDR: begin
                        if (cnt != ADDR_DONE) begin
                            sh  <= sh_next;
                            cnt <= cnt + CW'(1);
                            if (cnt == ADDR_LAST) begin
                                if (rd_sel) rd_addr <= sh_next[ADDR_WIDTH-1:0];
                                else        wr_addr <= sh_next[ADDR_WIDTH-1:0];
                            end
                        end
                    end
                    ST_RX_DATA: begin
                        sh <= sh_next;
                        if (cnt == DATA_LAST) begin
                            cnt     <= '0;
                            wr_word <= sh_next[DATA_WIDTH-1:0];
                            wr_pend <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_TX_DATA: begin
                        if (cnt == '0) begin
                            tx_run <= 1'b1;
                            if (tx_run) begin
                                miso <= mem_dout[DATA_WIDTH-1];
                                sh   <= SW'({mem_dout[DATA_WIDTH-2:0], 1'b0});
                                cnt  <= CW'(1);
                            end
                        end else begin
                            miso <= sh[DATA_WIDTH-1];
                            sh   <= {sh[SW-2:0], 1'b0};
                            cnt  <= (cnt == DATA_LAST) ? '0 : cnt + CW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_burst_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_ram_burst_slave : scoreboard bench, default and sweep DUTs  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_spi_ram_burst_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ss_n0, mosi0, miso0, ss_n1, mosi1, miso1;

    spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n0), .mosi(mosi0), .miso(miso0));

    spi_ram_burst_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .AUTO_INC(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n1), .mosi(mosi1), .miso(miso1));

    typedef struct {
        string       name;
        logic [15:0] act;
        logic [15:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [15:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model: plain memory arrays and write/read pointers per DUT.
    logic [7:0]  m0 [256];
    logic [15:0] m1 [16];
    int          wp0, rp0, wp1, rp1;
    logic [15:0] wbuf [8];

    logic        mon_rd = 1'b0;
    int          mon_sel = 0;
    logic        no_idle_chk = 1'b0;

    function automatic int aw_of(input int s); return (s == 0) ? 8 : 4;  endfunction
    function automatic int dw_of(input int s); return (s == 0) ? 8 : 16; endfunction

    function automatic void post(input string n, input logic [15:0] a, input logic [15:0] e);
        chk_q.push_back('{name: n, act: a, exp: e});
    endfunction

    task automatic drive(input int s, input logic ss, input logic m);
        @(negedge clk);
        if (s == 0) begin ss_n0 = ss; mosi0 = m; end
        else        begin ss_n1 = ss; mosi1 = m; end
    endtask

    task automatic start(input int s, input logic [1:0] cmd);
        drive(s, 1'b0, 1'b0);
        drive(s, 1'b0, cmd[1]);
        drive(s, 1'b0, cmd[0]);
    endtask

    task automatic end_frame(input int s);
        drive(s, 1'b1, 1'b0);
        drive(s, 1'b1, 1'b0);
    endtask

    task automatic set_addr(input int s, input logic [1:0] cmd, input logic [15:0] a);
        start(s, cmd);
        for (int i = aw_of(s) - 1; i >= 0; i--) drive(s, 1'b0, a[i]);
        end_frame(s);
        if (cmd == 2'b00) begin if (s == 0) wp0 = int'(a); else wp1 = int'(a); end
        else              begin if (s == 0) rp0 = int'(a); else rp1 = int'(a); end
    endtask

    task automatic wr_data(input int s, input int n);
        start(s, 2'b01);
        for (int k = 0; k < n; k++)
            for (int i = dw_of(s) - 1; i >= 0; i--) drive(s, 1'b0, wbuf[k][i]);
        end_frame(s);
        for (int k = 0; k < n; k++) begin
            if (s == 0) begin m0[wp0] = wbuf[k][7:0]; wp0 = (wp0 + 1) % 256; end
            else        begin m1[wp1] = wbuf[k]; end
        end
    endtask

    task automatic rd_data(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            if (s == 0) exp_q.push_back({8'h00, m0[(rp0 + k) % 256]});
            else        exp_q.push_back(m1[rp1]);
        end
        mon_sel = s;
        mon_rd  = 1'b1;
        start(s, 2'b11);
        repeat (1 + n * dw_of(s)) drive(s, 1'b0, 1'($urandom_range(0, 1)));
        end_frame(s);
        mon_rd = 1'b0;
        post("rd_words_left", 16'(exp_q.size()), 16'd0);
    endtask

    // Monitor: drains posted checks, deserialises miso during read frames,
    // and flags any miso activity outside the data window.
    int          fe0 = 0, fe1 = 0, nb = 0, fe;
    logic [15:0] wacc = '0, e, mask;
    logic        msel, ssel;
    chk_t        c;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            fe0 = ss_n0 ? 0 : fe0 + 1;
            fe1 = ss_n1 ? 0 : fe1 + 1;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                checks++;
                if (c.act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
                end
            end
            fe   = (mon_sel == 0) ? fe0 : fe1;
            msel = (mon_sel == 0) ? miso0 : miso1;
            ssel = (mon_sel == 0) ? ss_n0 : ss_n1;
            mask = (dw_of(mon_sel) == 16) ? 16'hFFFF : 16'h00FF;
            if (mon_rd && !ssel && fe >= 5) begin
                wacc = {wacc[14:0], msel};
                nb++;
                if (nb == dw_of(mon_sel)) begin
                    nb = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_word: got %h expected none", wacc & mask);
                    end else begin
                        e = exp_q.pop_front();
                        if ((wacc & mask) !== e) begin
                            errors++;
                            $display("FAIL rd_word dut%0d: got %h expected %h", mon_sel, wacc & mask, e);
                        end
                    end
                end
            end else begin
                nb = 0;
            end
            if (!no_idle_chk) begin
                checks += 2;
                if (!(mon_rd && mon_sel == 0 && fe0 >= 5) && miso0 !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_miso dut0: got %b expected 0", miso0);
                end
                if (!(mon_rd && mon_sel == 1 && fe1 >= 5) && miso1 !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_miso dut1: got %b expected 0", miso1);
                end
            end
        end
    end

    int a, n, off, len;

    initial begin
        rst_n = 1'b0; ss_n0 = 1'b1; mosi0 = 1'b0; ss_n1 = 1'b1; mosi1 = 1'b0;
        wp0 = 0; rp0 = 0; wp1 = 0; rp1 = 0;
        repeat (3) @(negedge clk);
        post("rst_miso0", {15'd0, miso0}, 16'd0);
        post("rst_miso1", {15'd0, miso1}, 16'd0);
        rst_n = 1'b1;

        set_addr(0, 2'b00, 16'h12);
        wbuf[0] = 16'hA5;
        wr_data(0, 1);
        set_addr(0, 2'b10, 16'h12);
        rd_data(0, 1);

        // Reset in the middle of a read frame, while the MSB (1) is on miso.
        set_addr(0, 2'b10, 16'h12);
        no_idle_chk = 1'b1;
        start(0, 2'b11);
        drive(0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        post("pre_rst_msb", {15'd0, miso0}, 16'd1);
        rst_n = 1'b0;
        #1;
        post("rst_mid_miso", {15'd0, miso0}, 16'd0);
        @(negedge clk);
        ss_n0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        no_idle_chk = 1'b0;
        wp0 = 0; rp0 = 0; wp1 = 0; rp1 = 0;
        wbuf[0] = 16'h77;
        wr_data(0, 1);
        rd_data(0, 1);

        set_addr(0, 2'b00, 16'hFE);
        wbuf[0] = 16'h11; wbuf[1] = 16'h22; wbuf[2] = 16'h33;
        wr_data(0, 3);
        set_addr(0, 2'b10, 16'hFE);
        rd_data(0, 3);
        set_addr(0, 2'b10, 16'h00);
        rd_data(0, 1);

        set_addr(0, 2'b00, 16'h40);
        wbuf[0] = 16'h01; wbuf[1] = 16'h02; wbuf[2] = 16'h03;
        wr_data(0, 3);
        set_addr(0, 2'b00, 16'h40);
        wbuf[0] = 16'h5A;
        wr_data(0, 1);
        start(0, 2'b01);
        repeat (5) drive(0, 1'b0, 1'b1);
        end_frame(0);
        set_addr(0, 2'b10, 16'h41);
        rd_data(0, 1);
        wbuf[0] = 16'hC3;
        wr_data(0, 1);
        set_addr(0, 2'b10, 16'h40);
        rd_data(0, 3);

        for (int it = 0; it < 8; it++) begin
            a = $urandom_range(0, 255);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) wbuf[k] = 16'($urandom_range(0, 255));
            set_addr(0, 2'b00, 16'(a));
            wr_data(0, n);
            off = $urandom_range(0, n - 1);
            len = $urandom_range(1, n - off);
            set_addr(0, 2'b10, 16'((a + off) % 256));
            rd_data(0, len);
        end

        set_addr(1, 2'b00, 16'h4);
        wbuf[0] = 16'h1234;
        wr_data(1, 1);
        set_addr(1, 2'b00, 16'h3);
        wbuf[0] = 16'hBEEF; wbuf[1] = 16'hCAFE;
        wr_data(1, 2);
        set_addr(1, 2'b10, 16'h3);
        rd_data(1, 2);
        set_addr(1, 2'b10, 16'h4);
        rd_data(1, 1);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
